// File: rtl/cpu_pipe_pkg.sv
// cpu_pipe_pkg: shared pipeline metadata types for the hazard tracker.
// Provides the register address width, the per-stage write-back
// descriptor, the watchdog state encoding and the reg-write qualifier.
package cpu_pipe_pkg;
    localparam int REG_ADDR_W = 5;
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] write_reg;
        logic                  reg_write;
        logic                  mem_read;
    } stage_meta_t;
    typedef enum logic [1:0] {RUN, STALLING, TRIPPED} wd_state_t;
    // A write to $0 is architecturally a no-op, so it is never reported.
    function automatic logic reg_write_out(input stage_meta_t s);
        return s.valid & s.reg_write & (s.write_reg != '0);
    endfunction
endpackage

// File: rtl/hazard_perf_counters.sv
// hazard_perf_counters: saturating stall/flush/retire counters plus stall watchdog.
// Ports: clk, reset (async, active-high); stall_ev/flush_ev/retire_ev event
// strobes; stall_cnt/flush_cnt/retire_cnt saturating counts; stall_timeout
// sticky flag once stall_ev has been held for MAX_STALL consecutive cycles.
module hazard_perf_counters
    import cpu_pipe_pkg::*;
#(
    parameter int CNT_W     = 32,
    parameter int MAX_STALL = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_ev,
    input  logic             flush_ev,
    input  logic             retire_ev,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] retire_cnt,
    output logic             stall_timeout
);
    localparam int SW = $clog2(MAX_STALL + 1);
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d, retire_cnt_q, retire_cnt_d;
    logic [SW-1:0]    run_q, run_d;
    wd_state_t        state_q, state_d;
    always_comb begin
        stall_cnt_d  = (stall_ev && stall_cnt_q != '1) ? stall_cnt_q + 1'b1 : stall_cnt_q;
        flush_cnt_d  = (flush_ev && flush_cnt_q != '1) ? flush_cnt_q + 1'b1 : flush_cnt_q;
        retire_cnt_d = (retire_ev && retire_cnt_q != '1) ? retire_cnt_q + 1'b1 : retire_cnt_q;
        state_d = state_q;
        run_d   = run_q;
        case (state_q)
            RUN: if (stall_ev) begin
                state_d = STALLING;
                run_d   = SW'(1);
            end
            STALLING: begin
                run_d   = stall_ev ? run_q + 1'b1 : '0;
                state_d = !stall_ev ? RUN : (run_q == SW'(MAX_STALL - 1)) ? TRIPPED : STALLING;
            end
            default: ;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            retire_cnt_q <= '0;
            run_q        <= '0;
            state_q      <= RUN;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            retire_cnt_q <= retire_cnt_d;
            run_q        <= run_d;
            state_q      <= state_d;
        end
    end
    assign stall_cnt     = stall_cnt_q;
    assign flush_cnt     = flush_cnt_q;
    assign retire_cnt    = retire_cnt_q;
    assign stall_timeout = state_q == TRIPPED;
endmodule

// File: rtl/hazard_pipe_tracker.sv
// hazard_pipe_tracker: ID/EX, EX/MEM, MEM/WB destination metadata for hazard detection.
// Ports: clk, reset (async, active-high); id_* decode descriptor; enable_1
// (0 = stall), reset1 (IF/ID flush, counted), reset2 (ID/EX bubble);
// ex_*/mem_*/wb_* qualified stage descriptors; retire pulse; perf counters
// and the sticky stall_timeout flag.
module hazard_pipe_tracker
    import cpu_pipe_pkg::*;
#(
    parameter int CNT_W     = 32,
    parameter int MAX_STALL = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_write_reg,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  enable_1,
    input  logic                  reset1,
    input  logic                  reset2,
    output logic [REG_ADDR_W-1:0] ex_write_reg,
    output logic                  ex_reg_write,
    output logic                  ex_mem_read,
    output logic [REG_ADDR_W-1:0] mem_write_reg,
    output logic                  mem_reg_write,
    output logic                  mem_mem_read,
    output logic [REG_ADDR_W-1:0] wb_write_reg,
    output logic                  wb_reg_write,
    output logic                  retire,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt,
    output logic [CNT_W-1:0]      retire_cnt,
    output logic                  stall_timeout
);
    stage_meta_t idex_q, idex_d, exmem_q, memwb_q;
    // The flush wins over a stall: a stalled-but-flushed ID/EX still becomes a bubble.
    always_comb begin
        idex_d = (reset2 || !id_valid) ? '0 : '{valid: 1'b1, write_reg: id_write_reg, reg_write: id_reg_write, mem_read: id_mem_read};
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
        end else begin
            idex_q  <= idex_d;
            exmem_q <= idex_q;
            memwb_q <= exmem_q;
        end
    end
    assign ex_write_reg  = idex_q.write_reg;
    assign ex_reg_write  = reg_write_out(idex_q);
    assign ex_mem_read   = idex_q.valid & idex_q.mem_read;
    assign mem_write_reg = exmem_q.write_reg;
    assign mem_reg_write = reg_write_out(exmem_q);
    assign mem_mem_read  = exmem_q.valid & exmem_q.mem_read;
    assign wb_write_reg  = memwb_q.write_reg;
    assign wb_reg_write  = reg_write_out(memwb_q);
    assign retire        = memwb_q.valid;
    hazard_perf_counters #(.CNT_W(CNT_W), .MAX_STALL(MAX_STALL)) u_perf (
        .clk          (clk),
        .reset        (reset),
        .stall_ev     (!enable_1),
        .flush_ev     (reset1),
        .retire_ev    (retire),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt),
        .retire_cnt   (retire_cnt),
        .stall_timeout(stall_timeout)
    );
endmodule

// File: doc/hazard_pipe_tracker.md
Name: hazard_pipe_tracker

Overview:
Holds the destination-register metadata for the ID/EX, EX/MEM and MEM/WB pipeline registers.
- Acts on the hazard unit's stall/flush controls and produces the per-stage write-back descriptors (dest reg, reg-write, load flag) that the hazard unit consumes for forwarding and load-use detection.
- Sits beside the datapath pipeline registers in the pipelined CPU.
- Adds saturating stall/flush/retire performance counters and a stall watchdog.

Parameters:
REG_ADDR_W, 5, register address width
CNT_W, 32, performance counter width
MAX_STALL, 4, consecutive stall cycles that trip the watchdog (>=2)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
id_valid  in  1  decode stage holds a real instruction
id_write_reg  in  REG_ADDR_W  decode destination register
id_reg_write  in  1  decode instruction writes the register file
id_mem_read  in  1  decode instruction is a load
enable_1  in  1  PC enable from hazard unit (0 = stall)
reset1  in  1  IF/ID flush (link/jump); counted only
reset2  in  1  ID/EX flush (bubble insert)
ex_write_reg  out  REG_ADDR_W  writeReg1 to hazard unit
ex_reg_write  out  1  regWrite1
ex_mem_read  out  1  readFlag1
mem_write_reg  out  REG_ADDR_W  writeReg2
mem_reg_write  out  1  regWrite2
mem_mem_read  out  1  readFlag2
wb_write_reg  out  REG_ADDR_W  write-back destination
wb_reg_write  out  1  write-back enable
retire  out  1  1-cycle pulse, valid instruction in WB
stall_cnt  out  CNT_W  cycles with enable_1=0
flush_cnt  out  CNT_W  cycles with reset1=1
retire_cnt  out  CNT_W  retired instructions
stall_timeout  out  1  sticky watchdog flag

Behaviour:
- Reset (async, immediate): all stage valid/reg_write/mem_read/write_reg = 0, counters = 0, stall_timeout = 0, retire = 0.
- Each stage register holds {valid, write_reg, reg_write, mem_read}.
- ID/EX update, per rising edge:
  - reset2=1 → bubble (all fields 0). Flush overrides everything, including enable_1=0 in the same cycle.
  - Otherwise load the id_* fields. id_valid=0 also loads a bubble.
- EX/MEM ← ID/EX and MEM/WB ← EX/MEM every cycle, unconditionally. Stalls never freeze the back end.
- Latency: a decode instruction appears on ex_* 1 cycle after capture, mem_* after 2, wb_* after 3.
- Output qualification:
  - *_reg_write = stored reg_write AND valid AND (write_reg != 0). A write to $0 is never reported.
  - *_mem_read is gated by valid.
  - write_reg outputs pass raw.
- retire = MEM/WB valid, registered (no combinational path from inputs).
- Counters: +1 per qualifying cycle and saturate at all-ones (no wrap).
  - stall_cnt: enable_1=0.
  - flush_cnt: reset1=1.
  - retire_cnt: retire=1.
  - Simultaneous events increment each counter independently.
- Watchdog FSM:
  - RUN: consecutive-stall counter is 0. enable_1=0 → STALLING with counter = 1.
  - STALLING: enable_1=0 → counter+1; on reaching MAX_STALL → TRIPPED and set stall_timeout. enable_1=1 → RUN with counter cleared.
  - TRIPPED: stall_timeout stays 1 until reset. Counters keep running.
- A normal load-use stall (1 cycle) must never trip the watchdog.
- Reset asserted mid-stall or mid-flush clears everything in the same cycle. The first post-reset edge behaves as from RUN.

Decomposition:
- Shared package cpu_pipe_pkg:
  - REG_ADDR_W constant.
  - stage_meta_t typedef {valid, write_reg, reg_write, mem_read}.
  - Watchdog state enum {RUN, STALLING, TRIPPED}.
- Sub-module hazard_perf_counters: the three saturating counters plus the watchdog FSM. The top module keeps the three stage registers and the output qualification.

Test Plan:
- Reset then id_valid=1, write_reg=8, reg_write=1, mem_read=1 for 1 cycle → ex_* shows 8/1/1 next cycle, mem_* the cycle after, wb_write_reg=8 with retire=1 at cycle 3, retire_cnt=1.
- Load-use: enable_1=0 and reset2=1 for 1 cycle → ID/EX becomes a bubble (ex_reg_write=0), stall_cnt=1, stall_timeout stays 0.
- id_write_reg=0 with reg_write=1 → ex_reg_write, mem_reg_write, wb_reg_write all 0 while retire still pulses.
- enable_1=0 held for MAX_STALL=4 cycles → stall_timeout rises on the 4th edge and stays 1 after enable_1 returns to 1, until reset.
- CNT_W=3 variant: 9 reset1 pulses → flush_cnt saturates at 7.
- Assert reset asynchronously between edges mid-pipeline → all outputs 0 immediately, with no retire pulse afterward.
